// File: rtl/lsu_nbload_tracker_pkg.sv
// Shared LSU types: tracker entry layout and depth limit for the
// non-blocking load tracker.
package veer_types;

  localparam int NBLOAD_MAX_DEPTH = 16;
  localparam int NBLOAD_RD_W      = 5;

  typedef struct packed {
    logic                   valid;
    logic                   wb;
    logic [NBLOAD_RD_W-1:0] rd;
  } nbload_entry_t;

  // x0 is hardwired to zero, so it can never carry a hazard.
  function automatic logic rd_hazard(nbload_entry_t e, logic [NBLOAD_RD_W-1:0] rd);
    return e.valid && e.wb && (e.rd == rd) && (e.rd != '0);
  endfunction

endpackage

// File: rtl/lsu_nbload_tracker_ffs.sv
// Find-first-zero over the tracker valid vector: the lowest free entry
// index plus a flag saying whether any entry is free.
module lsu_nbload_ffs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  output logic [TAG_W-1:0] index,
  output logic             any_free
);

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no latch can be inferred.
  always_comb begin
    index    = '0;
    any_free = 1'b0;
    // Scanning downwards lets the lowest free index overwrite the others.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        index    = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_nbload_tracker.sv
// Outstanding non-blocking load tracker: tag allocation, WAW supersession,
// flush marking, zero-cycle writeback resolution and register-hazard CAM.
module lsu_nbload_tracker
  import veer_types::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int NUM_Q = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               alloc_valid,
  input  logic [4:0]         alloc_rd,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               wb_valid,
  input  logic [TAG_W-1:0]   wb_tag,
  output logic [4:0]         wb_rd,
  output logic               wb_wen,
  output logic               wb_err,
  input  logic               flush,
  input  logic [NUM_Q*5-1:0] q_rd,
  output logic [NUM_Q-1:0]   q_hit,
  output logic [TAG_W:0]     count,
  output logic               empty
);

  localparam int CNT_W = TAG_W + 1;

  nbload_entry_t    entry_q [DEPTH];
  nbload_entry_t    entry_d [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [TAG_W-1:0] free_idx;
  logic             any_free;
  logic             alloc_acc;
  nbload_entry_t    wb_entry;
  logic             wb_hit;
  logic [CNT_W-1:0] count_v;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) valid_vec[i] = entry_q[i].valid;
  end

  lsu_nbload_ffs #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ffs (
    .valid    (valid_vec),
    .index    (free_idx),
    .any_free (any_free)
  );

  assign alloc_ready = any_free;
  assign alloc_tag   = free_idx;
  assign alloc_acc   = alloc_valid && any_free && !flush;

  // Writeback lookup reads only registered state, so a same-cycle
  // allocation, flush or supersession never changes what is reported.
  always_comb begin
    wb_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_tag == TAG_W'(i)) wb_entry = entry_q[i];
    end
  end

  assign wb_hit = wb_valid && wb_entry.valid;
  assign wb_rd  = wb_hit ? wb_entry.rd : 5'd0;
  assign wb_wen = wb_hit && wb_entry.wb;
  assign wb_err = wb_valid && !wb_entry.valid;

  // Later assignments override earlier ones: free, flush, supersession,
  // then allocation as the highest priority update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (wb_hit && wb_tag == TAG_W'(i)) entry_d[i] = '0;
      if (flush && entry_d[i].valid) entry_d[i].wb = 1'b0;
      if (alloc_acc && free_idx != TAG_W'(i) && entry_d[i].valid &&
          entry_d[i].rd == alloc_rd) begin
        entry_d[i].wb = 1'b0;
      end
      if (alloc_acc && free_idx == TAG_W'(i)) begin
        entry_d[i].valid = 1'b1;
        entry_d[i].wb    = 1'b1;
        entry_d[i].rd    = alloc_rd;
      end
    end
  end

  // NOTE: the entry array is reset, not left as uninitialised storage,
  // because valid bits must clear asynchronously for tags to be free.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  always_comb begin
    count_v = '0;
    for (int i = 0; i < DEPTH; i++) count_v = count_v + CNT_W'(entry_q[i].valid);
  end

  assign count = count_v;
  assign empty = (count_v == '0);

  always_comb begin
    q_hit = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_hazard(entry_q[i], q_rd[5*k +: 5])) q_hit[k] = 1'b1;
      end
    end
  end

  // Decode must hold off allocation while the tracker is full.
  a_alloc_when_full : assert property (
    @(posedge clk) disable iff (!rst_l) !(alloc_valid && !alloc_ready)
  );

endmodule

// File: tb/tb_lsu_nbload_tracker.sv
// Directed bench for lsu_nbload_tracker with hand-computed expectations,
// DEPTH=4 and NUM_Q=4.
module tb_lsu_nbload_tracker;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int NUM_Q = 4;

  logic               clk = 1'b0;
  logic               rst_l;
  logic               alloc_valid;
  logic [4:0]         alloc_rd;
  logic               alloc_ready;
  logic [TAG_W-1:0]   alloc_tag;
  logic               wb_valid;
  logic [TAG_W-1:0]   wb_tag;
  logic [4:0]         wb_rd;
  logic               wb_wen;
  logic               wb_err;
  logic               flush;
  logic [NUM_Q*5-1:0] q_rd;
  logic [NUM_Q-1:0]   q_hit;
  logic [TAG_W:0]     count;
  logic               empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_nbload_tracker #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .NUM_Q (NUM_Q)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_rd       (wb_rd),
    .wb_wen      (wb_wen),
    .wb_err      (wb_err),
    .flush       (flush),
    .q_rd        (q_rd),
    .q_hit       (q_hit),
    .count       (count),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each step leaves inputs changing 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [31:0] exp_tag);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    #1;
    check($sformatf("alloc_tag rd=%0d", rd), 32'(alloc_tag), exp_tag);
    next_cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [1:0] tag, input logic [31:0] exp_rd,
                       input logic [31:0] exp_wen, input logic [31:0] exp_err);
    wb_valid = 1'b1;
    wb_tag   = tag;
    #1;
    check($sformatf("wb_rd tag=%0d", tag),  32'(wb_rd),  exp_rd);
    check($sformatf("wb_wen tag=%0d", tag), 32'(wb_wen), exp_wen);
    check($sformatf("wb_err tag=%0d", tag), 32'(wb_err), exp_err);
    next_cycle();
    wb_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " alloc_ready"}, 32'(alloc_ready), 32'd1);
    check({tag, " alloc_tag"},   32'(alloc_tag),   32'd0);
    check({tag, " count"},       32'(count),       32'd0);
    check({tag, " empty"},       32'(empty),       32'd1);
    check({tag, " q_hit"},       32'(q_hit),       32'd0);
    check({tag, " wb_rd"},       32'(wb_rd),       32'd0);
    check({tag, " wb_wen"},      32'(wb_wen),      32'd0);
    check({tag, " wb_err"},      32'(wb_err),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    flush       = 1'b0;
    q_rd        = {5'd11, 5'd11, 5'd11, 5'd11};
    #12;
    check_idle("reset");
    rst_l = 1'b1;
    next_cycle();

    // Fill all four entries.
    do_alloc(5'd1, 0);
    do_alloc(5'd2, 1);
    do_alloc(5'd3, 2);
    do_alloc(5'd4, 3);
    #1;
    check("full alloc_ready", 32'(alloc_ready), 32'd0);
    check("full count",       32'(count),       32'd4);
    check("full empty",       32'(empty),       32'd0);

    // Freed slot becomes allocatable only on the following cycle.
    wb_valid = 1'b1;
    wb_tag   = 2'd2;
    #1;
    check("wb2 alloc_ready same cycle", 32'(alloc_ready), 32'd0);
    wb_valid = 1'b0;
    do_wb(2'd2, 3, 1, 0);
    check("after wb2 count", 32'(count),       32'd3);
    check("after wb2 ready", 32'(alloc_ready), 32'd1);
    do_alloc(5'd9, 2);
    check("refill count", 32'(count), 32'd4);
    do_wb(2'd0, 1, 1, 0);
    do_wb(2'd1, 2, 1, 0);
    do_wb(2'd2, 9, 1, 0);
    do_wb(2'd3, 4, 1, 0);
    check("drained count", 32'(count), 32'd0);

    // WAW: the older load on rd=5 must not write the register file.
    do_alloc(5'd5, 0);
    do_alloc(5'd5, 1);
    do_wb(2'd0, 5, 0, 0);
    do_wb(2'd1, 5, 1, 0);

    // Flush with two loads pending; the same-cycle allocation is dropped.
    do_alloc(5'd6, 0);
    do_alloc(5'd7, 1);
    q_rd = {5'd0, 5'd0, 5'd7, 5'd6};
    #1;
    check("pre-flush q_hit", 32'(q_hit), 32'b0011);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd10;
    next_cycle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    #1;
    check("flush count",  32'(count), 32'd2);
    check("flush q_hit",  32'(q_hit), 32'b0000);
    do_wb(2'd0, 6, 0, 0);
    check("flush drain1 count", 32'(count), 32'd1);
    do_wb(2'd1, 7, 0, 0);
    check("flush drain2 count", 32'(count), 32'd0);
    do_wb(2'd3, 0, 0, 1);
    check("err empty count", 32'(count), 32'd0);

    // Multi-port queries; rd=0 never hits.
    do_alloc(5'd8, 0);
    do_alloc(5'd0, 1);
    q_rd = {5'd0, 5'd8, 5'd8, 5'd3};
    #1;
    check("q_hit multiport", 32'(q_hit), 32'b0110);
    do_wb(2'd3, 0, 0, 1);
    check("err count unchanged", 32'(count), 32'd2);
    do_wb(2'd0, 8, 1, 0);
    do_wb(2'd1, 0, 1, 0);

    // A query does not see an allocation from the same cycle.
    q_rd        = {5'd8, 5'd8, 5'd8, 5'd8};
    alloc_valid = 1'b1;
    alloc_rd    = 5'd8;
    #1;
    check("same-cycle q_hit", 32'(q_hit), 32'b0000);
    next_cycle();
    alloc_valid = 1'b0;
    #1;
    check("next-cycle q_hit", 32'(q_hit), 32'b1111);

    // Flush and writeback together: writeback sees the pre-flush wb bit.
    flush    = 1'b1;
    wb_valid = 1'b1;
    wb_tag   = 2'd0;
    #1;
    check("flush+wb wen", 32'(wb_wen), 32'd1);
    check("flush+wb rd",  32'(wb_rd),  32'd8);
    next_cycle();
    flush    = 1'b0;
    wb_valid = 1'b0;
    #1;
    check("flush+wb count", 32'(count), 32'd0);

    // WAW and writeback on the same rd in one cycle: pre-clear wb reported.
    do_alloc(5'd12, 0);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd12;
    wb_valid    = 1'b1;
    wb_tag      = 2'd0;
    #1;
    check("waw+wb wen", 32'(wb_wen), 32'd1);
    next_cycle();
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    do_wb(2'd1, 12, 1, 0);

    // Asynchronous reset with three loads pending.
    do_alloc(5'd11, 0);
    do_alloc(5'd13, 1);
    do_alloc(5'd14, 2);
    q_rd = {5'd11, 5'd11, 5'd11, 5'd11};
    #1;
    check("pre-reset count", 32'(count), 32'd3);
    check("pre-reset q_hit", 32'(q_hit), 32'b1111);
    rst_l = 1'b0;
    #1;
    check_idle("async reset");
    #2;
    rst_l = 1'b1;
    next_cycle();
    do_wb(2'd0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
